// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg
// Shared definitions for the sequential divide unit:
//   - state_e   : divider FSM states (IDLE / CALC / DONE)
//   - STATE_W   : state encoding width
//   - NEG_W     : working width of the shared negate helper (WIDTH <= NEG_W)
//   - cond_negate() : two's-complement conditional negate, also used to take
//                     magnitudes; shared with the ALU.
// -----------------------------------------------------------------------------
package seq_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NEG_W = 64;

  // Returns -x when neg is set, x otherwise. Callers zero-extend narrower
  // operands and truncate the result: the low bits of -x depend only on the
  // low bits of x, so this is exact for any width up to NEG_W.
  function automatic logic [NEG_W-1:0] cond_negate(input logic [NEG_W-1:0] x,
                                                   input logic             neg);
    return neg ? (~x + NEG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// -----------------------------------------------------------------------------
// seq_div_step
// One combinational restoring-division step.
// Ports:
//   i_rem  : current partial remainder (non-negative)
//   i_div  : divisor aligned to the quotient bit being resolved
//   o_rem  : partial remainder after the step
//   o_qbit : resolved quotient bit (1 when the subtraction did not underflow)
// -----------------------------------------------------------------------------
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int REM_W = 33
) (
  input  logic [REM_W-1:0] i_rem,
  input  logic [REM_W-1:0] i_div,
  output logic [REM_W-1:0] o_rem,
  output logic             o_qbit
);

  // One guard bit on top acts as the sign of the trial subtraction.
  logic [REM_W:0] w_trial;

  assign w_trial = {1'b0, i_rem} - {1'b0, i_div};
  assign o_qbit  = ~w_trial[REM_W];
  assign o_rem   = o_qbit ? w_trial[REM_W-1:0] : i_rem;

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider, one quotient bit per clock.
// q = a / b, r = a % b; b == 0 returns q = all ones, r = a, div_by_zero = 1
// one edge after accept. Otherwise the result appears WIDTH edges after accept.
// Optional feature macro: SEQ_DIV_SIGNED_EN adds the sgn port and truncating
// two's-complement division (C semantics); WIDTH must then be <= 64.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE, not in reset)
//   a, b                 : dividend, divisor (latched at accept)
//   sgn                  : signed operation (SEQ_DIV_SIGNED_EN only)
//   out_valid / out_ready: result handshake, result held under backpressure
//   q, r                 : quotient, remainder
//   div_by_zero          : result came from the b == 0 path
// -----------------------------------------------------------------------------
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REM_W = 2 * WIDTH + 1;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [REM_W-1:0] r_rem;
  logic [REM_W-1:0] r_div;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [REM_W-1:0] w_rem_next;
  logic             w_qbit;
  logic             w_b_zero;

  assign in_ready    = (r_state == S_IDLE) && !rst;
  assign out_valid   = (r_state == S_DONE);
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;
  assign w_b_zero    = (b == '0);

  seq_div_step #(
    .REM_W (REM_W)
  ) u_step (
    .i_rem  (r_rem),
    .i_div  (r_div),
    .o_rem  (w_rem_next),
    .o_qbit (w_qbit)
  );

  assign w_q_mag = {r_quo[WIDTH-2:0], w_qbit};

`ifdef SEQ_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_sa;
  logic w_sb;

  assign w_sa    = sgn & a[WIDTH-1];
  assign w_sb    = sgn & b[WIDTH-1];
  assign w_mag_a = WIDTH'(cond_negate(NEG_W'(a), w_sa));
  assign w_mag_b = WIDTH'(cond_negate(NEG_W'(b), w_sb));
  // MIN / -1 needs no special case: magnitude 2^(WIDTH-1) negates back to MIN.
  assign w_q_fix = WIDTH'(cond_negate(NEG_W'(w_q_mag), r_neg_q));
  assign w_r_fix = WIDTH'(cond_negate(NEG_W'(w_rem_next[WIDTH-1:0]), r_neg_r));
`else
  assign w_mag_a = a;
  assign w_mag_b = b;
  assign w_q_fix = w_q_mag;
  assign w_r_fix = w_rem_next[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_quo   <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // rst is low here, so in_ready is high and in_valid alone accepts.
          if (in_valid) begin
            r_a     <= a;
            r_dbz   <= w_b_zero;
            r_quo   <= '0;
            r_rem   <= REM_W'(w_mag_a);
            r_div   <= REM_W'(w_mag_b) << (WIDTH - 1);
            // Divide-by-zero takes a single pass through CALC.
            r_cnt   <= w_b_zero ? CNT_W'(1) : CNT_W'(WIDTH);
            r_state <= S_CALC;
`ifdef SEQ_DIV_SIGNED_EN
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_div <= r_div >> 1;
          r_quo <= w_q_mag;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            if (r_dbz) begin
              r_q <= '1;
              r_r <= r_a;
            end else begin
              r_q <= w_q_fix;
              r_r <= w_r_fix;
            end
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
